// File: rtl/stack_ctrl_if.sv
// Command/response channel between a stack user and stack_ctrl.
// The master issues commands; the slave (stack_ctrl) accepts them and
// returns POP/PEEK data as a one-cycle response pulse.
interface stack_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_data;

   modport master (
      output cmd_valid, cmd_op, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/stack_ctrl.sv
// Sequencing controller for one microForth hardware stack.
// TOS lives in a local register; entries 2..N live in an external stack RAM
// driven through stk_delta/stk_we/stk_wd, with the RAM's top entry (NOS)
// returned on stk_rd. Tracks depth and sticky overflow/underflow/opcode errors.
module stack_ctrl #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 512,
   parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   stack_ctrl_if.slave          cmd,
   output logic [CNT_WIDTH-1:0] depth,
   output logic                 empty,
   output logic                 full,
   output logic                 err_overflow,
   output logic                 err_underflow,
   output logic                 err_cmd,
   output logic [1:0]           stk_delta,
   output logic                 stk_we,
   output logic [WIDTH-1:0]     stk_wd,
   input  logic [WIDTH-1:0]     stk_rd
);

   typedef enum logic [2:0] {
      OP_NOP     = 3'b000,
      OP_PUSH    = 3'b001,
      OP_POP     = 3'b010,
      OP_PEEK    = 3'b011,
      OP_REPLACE = 3'b100,
      OP_CLEAR   = 3'b101
   } op_t;

   typedef enum logic [1:0] {
      IDLE,
      POP_WAIT,
      POP_LOAD,
      CLEAR
   } state_t;

   localparam logic [1:0] DELTA_HOLD = 2'b00;
   localparam logic [1:0] DELTA_INC  = 2'b01;
   localparam logic [1:0] DELTA_DEC  = 2'b11;

   localparam logic [CNT_WIDTH-1:0] DEPTH_MAX = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] TWO       = CNT_WIDTH'(2);

   state_t               state;
   logic [WIDTH-1:0]     tos;
   // RAM entries still to be popped off during CLEAR, after the current one.
   logic [CNT_WIDTH-1:0] clr_cnt;

   // Ready is combinational so that back-to-back commands can issue every cycle.
   assign cmd.cmd_ready = (state == IDLE) && !rst;
   assign empty         = (depth == '0);
   assign full          = (depth == DEPTH_MAX);

   // Single FSM: command decode, RAM sequencing and all registered outputs.
   // NOTE: every register here uses <= so all updates see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         tos           <= '0;
         depth         <= '0;
         clr_cnt       <= '0;
         cmd.rsp_valid <= 1'b0;
         cmd.rsp_data  <= '0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
         err_cmd       <= 1'b0;
         stk_delta     <= DELTA_HOLD;
         stk_we        <= 1'b0;
         stk_wd        <= '0;
      end else begin
         // Pulse-type outputs default to idle every cycle.
         cmd.rsp_valid <= 1'b0;
         stk_delta     <= DELTA_HOLD;
         stk_we        <= 1'b0;

         case (state)
            IDLE: begin
               if (cmd.cmd_valid && cmd.cmd_ready) begin
                  case (cmd.cmd_op)
                     OP_NOP: ;
                     OP_PUSH: begin
                        if (depth < DEPTH_MAX) begin
                           tos   <= cmd.cmd_data;
                           depth <= depth + ONE;
                           // Old TOS spills into the RAM only when it was valid.
                           if (depth != '0) begin
                              stk_we    <= 1'b1;
                              stk_delta <= DELTA_INC;
                              stk_wd    <= tos;
                           end
                        end else begin
                           err_overflow <= 1'b1;
                        end
                     end
                     OP_POP: begin
                        cmd.rsp_valid <= 1'b1;
                        if (depth != '0) begin
                           cmd.rsp_data <= tos;
                           depth        <= depth - ONE;
                           // Refill TOS from NOS only if the RAM holds an entry.
                           if (depth >= TWO) begin
                              stk_delta <= DELTA_DEC;
                              state     <= POP_WAIT;
                           end
                        end else begin
                           cmd.rsp_data  <= '0;
                           err_underflow <= 1'b1;
                        end
                     end
                     OP_PEEK: begin
                        cmd.rsp_valid <= 1'b1;
                        cmd.rsp_data  <= (depth == '0) ? '0 : tos;
                     end
                     OP_REPLACE: begin
                        if (depth != '0) tos <= cmd.cmd_data;
                        else             err_underflow <= 1'b1;
                     end
                     OP_CLEAR: begin
                        state <= CLEAR;
                        // First RAM pop is issued right away; count the rest.
                        if (depth >= TWO) begin
                           stk_delta <= DELTA_DEC;
                           clr_cnt   <= depth - TWO;
                        end else begin
                           clr_cnt   <= '0;
                        end
                     end
                     default: err_cmd <= 1'b1;
                  endcase
               end
            end

            POP_WAIT: state <= POP_LOAD;

            POP_LOAD: begin
               tos   <= stk_rd;
               state <= IDLE;
            end

            CLEAR: begin
               if (clr_cnt != '0) begin
                  stk_delta <= DELTA_DEC;
                  clr_cnt   <= clr_cnt - ONE;
               end else begin
                  depth         <= '0;
                  tos           <= '0;
                  err_overflow  <= 1'b0;
                  err_underflow <= 1'b0;
                  err_cmd       <= 1'b0;
                  state         <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural stack RAM model
// (synchronous read of the current top entry, write on pointer increment).
module tb_stack_ctrl;

   localparam int WIDTH = 16;
   localparam int DEPTH = 512;
   localparam int CW    = $clog2(DEPTH + 1);

   localparam logic [2:0] NOP     = 3'b000;
   localparam logic [2:0] PUSH    = 3'b001;
   localparam logic [2:0] POP     = 3'b010;
   localparam logic [2:0] PEEK    = 3'b011;
   localparam logic [2:0] REPLACE = 3'b100;
   localparam logic [2:0] CLEAR   = 3'b101;
   localparam logic [2:0] RSVD    = 3'b110;

   logic             clk = 1'b0;
   logic             rst;
   logic [CW-1:0]    depth;
   logic             empty, full;
   logic             err_overflow, err_underflow, err_cmd;
   logic [1:0]       stk_delta;
   logic             stk_we;
   logic [WIDTH-1:0] stk_wd;
   logic [WIDTH-1:0] stk_rd;

   int n_tests = 0;
   int n_fail  = 0;

   stack_ctrl_if #(.WIDTH(WIDTH)) bus ();

   stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd           (bus),
      .depth         (depth),
      .empty         (empty),
      .full          (full),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow),
      .err_cmd       (err_cmd),
      .stk_delta     (stk_delta),
      .stk_we        (stk_we),
      .stk_wd        (stk_wd),
      .stk_rd        (stk_rd)
   );

   always #5 clk = ~clk;

   // Stack RAM model: reset realigns the pointer together with the controller.
   logic [WIDTH-1:0] mem [0:1023];
   logic [9:0]       sp;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sp     <= '0;
         stk_rd <= '0;
      end else begin
         stk_rd <= mem[sp];
         if (stk_delta == 2'b01) begin
            sp <= sp + 10'd1;
            if (stk_we) mem[sp + 10'd1] <= stk_wd;
         end else if (stk_delta == 2'b11) begin
            sp <= sp - 10'd1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle command presentation; outputs of the accepting edge are
   // visible when this returns.
   task automatic issue(input logic [2:0] op, input logic [15:0] data);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = data;
      step();
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = NOP;
   endtask

   // Counts cycles with cmd_ready low and cycles with stk_delta=11 after acceptance.
   task automatic measure_busy(input int budget, output int low, output int dec);
      low = 0;
      dec = 0;
      while (!bus.cmd_ready && low < budget) begin
         if (stk_delta == 2'b11) dec++;
         low++;
         step();
      end
      check("busy_bound_ready", 32'(bus.cmd_ready), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int low, dec;

      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = NOP;
      bus.cmd_data  = '0;

      // Reset state.
      step(); step();
      check("rst_ready",     32'(bus.cmd_ready), 0);
      check("rst_depth",     32'(depth), 0);
      check("rst_empty",     32'(empty), 1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_data",  32'(bus.rsp_data), 0);
      check("rst_delta",     32'(stk_delta), 0);
      check("rst_we",        32'(stk_we), 0);
      check("rst_wd",        32'(stk_wd), 0);
      check("rst_errs",      32'({err_overflow, err_underflow, err_cmd}), 0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 32'(bus.cmd_ready), 1);

      // Three back-to-back pushes.
      issue(PUSH, 16'h1111);
      check("push1_depth", 32'(depth), 1);
      check("push1_we",    32'(stk_we), 0);
      check("push1_delta", 32'(stk_delta), 0);
      issue(PUSH, 16'h2222);
      check("push2_we",    32'(stk_we), 1);
      check("push2_wd",    32'(stk_wd), 32'h1111);
      check("push2_delta", 32'(stk_delta), 1);
      issue(PUSH, 16'h3333);
      check("push3_we",    32'(stk_we), 1);
      check("push3_wd",    32'(stk_wd), 32'h2222);
      check("push3_delta", 32'(stk_delta), 1);
      check("push3_depth", 32'(depth), 3);
      check("push3_ready", 32'(bus.cmd_ready), 1);
      issue(PEEK, 16'h0);
      check("peek_valid", 32'(bus.rsp_valid), 1);
      check("peek_data",  32'(bus.rsp_data), 32'h3333);
      check("peek_we",    32'(stk_we), 0);

      // Three pops: two refill from RAM, the last does not.
      issue(POP, 16'h0);
      check("pop1_valid", 32'(bus.rsp_valid), 1);
      check("pop1_data",  32'(bus.rsp_data), 32'h3333);
      check("pop1_depth", 32'(depth), 2);
      measure_busy(10, low, dec);
      check("pop1_busy",  32'(low), 2);
      check("pop1_dec",   32'(dec), 1);
      issue(POP, 16'h0);
      check("pop2_data",  32'(bus.rsp_data), 32'h2222);
      check("pop2_depth", 32'(depth), 1);
      measure_busy(10, low, dec);
      check("pop2_busy",  32'(low), 2);
      issue(POP, 16'h0);
      check("pop3_valid", 32'(bus.rsp_valid), 1);
      check("pop3_data",  32'(bus.rsp_data), 32'h1111);
      check("pop3_delta", 32'(stk_delta), 0);
      check("pop3_ready", 32'(bus.cmd_ready), 1);
      check("pop3_empty", 32'(empty), 1);

      // Underflow on empty.
      issue(POP, 16'h0);
      check("uf_valid", 32'(bus.rsp_valid), 1);
      check("uf_data",  32'(bus.rsp_data), 0);
      check("uf_flag",  32'(err_underflow), 1);
      check("uf_depth", 32'(depth), 0);
      step();
      check("uf_pulse", 32'(bus.rsp_valid), 0);

      // Fill to DEPTH, then overflow.
      for (int i = 1; i <= DEPTH; i++) issue(PUSH, 16'(i));
      check("fill_depth", 32'(depth), DEPTH);
      check("fill_full",  32'(full), 1);
      issue(PUSH, 16'hBEEF);
      check("of_flag",  32'(err_overflow), 1);
      check("of_depth", 32'(depth), DEPTH);
      check("of_we",    32'(stk_we), 0);
      issue(PEEK, 16'h0);
      check("of_peek",  32'(bus.rsp_data), 32'h0200);

      // CLEAR from full.
      issue(CLEAR, 16'h0);
      measure_busy(600, low, dec);
      check("clr_full_busy", 32'(low), DEPTH - 1);
      check("clr_full_dec",  32'(dec), DEPTH - 1);
      check("clr_full_depth", 32'(depth), 0);
      check("clr_full_errs", 32'({err_overflow, err_underflow, err_cmd}), 0);

      // REPLACE on empty, then push five, replace, reserved op, CLEAR at 5.
      issue(REPLACE, 16'h1234);
      check("rep_empty_uf", 32'(err_underflow), 1);
      issue(PEEK, 16'h0);
      check("rep_empty_peek", 32'(bus.rsp_data), 0);
      for (int i = 1; i <= 5; i++) issue(PUSH, 16'(i * 16'h10));
      issue(REPLACE, 16'hAAAA);
      issue(PEEK, 16'h0);
      check("rep_peek",  32'(bus.rsp_data), 32'hAAAA);
      check("rep_depth", 32'(depth), 5);
      issue(RSVD, 16'h0);
      check("rsvd_flag",  32'(err_cmd), 1);
      check("rsvd_depth", 32'(depth), 5);
      issue(CLEAR, 16'h0);
      measure_busy(20, low, dec);
      check("clr5_busy",  32'(low), 4);
      check("clr5_dec",   32'(dec), 4);
      check("clr5_depth", 32'(depth), 0);
      check("clr5_errs",  32'({err_overflow, err_underflow, err_cmd}), 0);
      check("clr5_delta", 32'(stk_delta), 0);

      // Reset in the middle of CLEAR.
      for (int i = 0; i < 3; i++) issue(PUSH, 16'(16'h0700 + i));
      issue(CLEAR, 16'h0);
      step();
      rst = 1'b1;
      #1;
      check("rclr_ready", 32'(bus.cmd_ready), 0);
      check("rclr_delta", 32'(stk_delta), 0);
      check("rclr_depth", 32'(depth), 0);
      step();
      check("rclr_hold_ready", 32'(bus.cmd_ready), 0);
      rst = 1'b0;
      #1;
      check("rclr_release_ready", 32'(bus.cmd_ready), 1);

      // Reset in the middle of POP_WAIT.
      issue(PUSH, 16'h0A0A);
      issue(PUSH, 16'h0B0B);
      issue(PUSH, 16'h0C0C);
      issue(POP, 16'h0);
      check("rpop_pre_data", 32'(bus.rsp_data), 32'h0C0C);
      rst = 1'b1;
      #1;
      check("rpop_valid", 32'(bus.rsp_valid), 0);
      check("rpop_data",  32'(bus.rsp_data), 0);
      check("rpop_delta", 32'(stk_delta), 0);
      check("rpop_depth", 32'(depth), 0);
      check("rpop_ready", 32'(bus.cmd_ready), 0);
      step();
      rst = 1'b0;
      #1;
      check("rpop_release_ready", 32'(bus.cmd_ready), 1);
      issue(PUSH, 16'h5A5A);
      issue(PEEK, 16'h0);
      check("rpop_after_peek",  32'(bus.rsp_data), 32'h5A5A);
      check("rpop_after_depth", 32'(depth), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
